dmem_arbiter: RTL
=================

# dmem_arbiter

- Shares the single-port data memory between two requesters: the RISC-V core load/store port (port C) and the debug/program-loader port (port D).
- Grants one access per cycle and returns read data one cycle later, tagged to the owner.
- Supports a debug lock so the loader can own memory for a burst.
- Sits between the core's `dataadr`/`writedata`/`memwrite` path and the data memory. The core stalls while `c_req && !c_gnt`.

## Interface
- `AW`, default 32: address width, passed through unmodified.
- `DW`, default 32: data width.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-low reset, sampled on `clk` rising edge.
- `c_req` in 1: core access request.
- `c_we` in 1: core write enable; 1 = store, 0 = load.
- `c_addr` in AW: core address.
- `c_wdata` in DW: core store data.
- `c_gnt` out 1: core access accepted this cycle (combinational).
- `c_rvalid` out 1: core read data valid (registered).
- `c_rdata` out DW: core read data.
- `d_req`, `d_we`, `d_addr`, `d_wdata`: same as the C-port inputs, for the debug port.
- `d_lock` in 1: debug port requests exclusive ownership.
- `d_gnt`, `d_rvalid`, `d_rdata`: same as the C-port outputs, for the debug port.
- `m_en` out 1: memory access strobe.
- `m_we` out 1: memory write enable.
- `m_addr` out AW: memory address.
- `m_wdata` out DW: memory write data.
- `m_rdata` in DW: memory read data, valid the cycle after an `m_en && !m_we` access.

## Operation
- **Registered state:**
  - `state`: ARB or LOCKED.
  - `last`: last granted port.
  - `rd_pend`: read in flight.
  - `rd_own`: owner of the read in flight.
- **ARB state:**
  - Only one port requesting: that port is granted.
  - Both ports requesting: the winner is chosen by the arbitration policy (see Configuration).
- **LOCKED state:**
  - Only port D may be granted; `c_gnt` = 0 regardless of `c_req`.
- **Transitions:**
  - ARB → LOCKED when port D is granted and `d_lock` = 1 in that cycle.
  - LOCKED → ARB on the first cycle with `d_lock` = 0. No grant to C occurs in that cycle; C is eligible the next cycle.
- **Memory side and per-grant updates:**
  - `m_en` = `c_gnt | d_gnt`.
  - `m_we`, `m_addr`, `m_wdata` are muxed from the granted port; all are 0 when nothing is granted.
  - `last` updates only on a grant.
- **Read return:**
  - On a granted read, `rd_pend` ← 1 and `rd_own` ← the granted port.
  - Next cycle, that port's `rvalid` = 1 and its `rdata` = `m_rdata`.
  - The non-owner's `rdata` = 0; a port's `rdata` = 0 whenever its `rvalid` = 0.
- **Writes:** never produce `rvalid`.
- **Back-to-back reads:** a grant is allowed every cycle, including a read grant in the same cycle the previous read returns (fully pipelined, no bubble).
- **Reset:**
  - Applies when `reset` = 0 at a rising edge.
  - Register values: `state` = ARB, `last` = D (so C wins the first tie), `rd_pend` = 0, `c_rvalid` = `d_rvalid` = 0.
  - While `reset` = 0, all grants and `m_en` are forced to 0.
  - A read in flight when reset is applied is dropped: no `rvalid` is produced for it.

## Timing
- Grant latency: 0 cycles. `gnt` is combinational from `req` and state in the same cycle.
- Read latency: 1 cycle from grant to `rvalid`. Write completes at the grant edge.
- `req` must be held until `gnt`. Inputs may change after the granted edge.
- Combinational path `req` → `gnt` → `m_*`. There is no path from `m_rdata` to any grant.

## Configuration
- `DMEM_ARB_RR_EN` defined:
  - Round-robin.
  - On a tie, grant the port ≠ `last`. Each port is guaranteed a grant within 2 cycles of asserting `req` in ARB.
- Not defined:
  - Fixed priority; C always wins ties, and D may starve while C requests continuously.
  - `last` is still maintained but unused.
  - The lock behaviour is identical in both modes.

## Test plan
- **Reset and idle:**
  - Stimulus: hold `reset` = 0 for 3 cycles with `c_req` = `d_req` = 1.
  - Required: `c_gnt` = `d_gnt` = `m_en` = 0 and both `rvalid` = 0.
  - Release reset with no requests: all outputs remain 0.
- **Core store then load:**
  - Stimulus: C writes 7 to address 84, then reads address 84.
  - Required: `m_we` = 1, `m_addr` = 84, `m_wdata` = 7 on cycle 1.
  - Required: `c_rvalid` = 1 with `c_rdata` = 7 on cycle 3.
  - Required: `d_rvalid` = 0 throughout.
- **Tie arbitration:**
  - Stimulus: `c_req` = `d_req` = 1 continuously for 4 cycles.
  - With RR: grants go C, D, C, D.
  - Without RR: C, C, C, C with `d_gnt` = 0.
- **Lock:**
  - Stimulus: D is granted with `d_lock` = 1 while `c_req` = 1 for 5 cycles; `d_lock` drops at cycle 4.
  - Required: `c_gnt` = 0 through cycle 4; C is granted at cycle 5.
- **Pipelined reads across owners:**
  - Stimulus: C reads address 80, then D reads address 84 on the next cycle; memory holds 80→0x11 and 84→0x22.
  - Required: `c_rvalid`/`c_rdata` = 0x11, then `d_rvalid`/`d_rdata` = 0x22 on consecutive cycles.
- **Reset mid-read:**
  - Stimulus: C read granted, `reset` = 0 on the next edge.
  - Required: `c_rvalid` stays 0 and `state` = ARB afterwards.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbiter that shares one single-port data memory between the core (C) and the debug loader (D).
// Optional feature: define DMEM_ARB_RR_EN for round-robin tie-breaking (default is fixed C priority).
module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic          d_lock,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_t state_reg;
    logic   last_reg;
    logic   rd_pend_reg;
    logic   rd_own_reg;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       tie_to_d;

    assign req = {d_req, c_req};

`ifdef DMEM_ARB_RR_EN
    assign tie_to_d = (last_reg == PORT_C);
`else
    // Fixed priority: last is still tracked so both builds share one register map.
    logic last_unused;
    assign last_unused = last_reg;
    assign tie_to_d    = 1'b0;
`endif

    // Grants are purely combinational from requests and registered state.
    always_comb begin
        gnt = 2'b00;
        if (reset) begin
            if (state_reg == ST_LOCKED) begin
                gnt[1] = d_req;
            end else if (&req) begin
                gnt = tie_to_d ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    assign c_gnt = gnt[0];
    assign d_gnt = gnt[1];
    assign m_en  = |gnt;

    always_comb begin
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        if (gnt[0]) begin
            m_we    = c_we;
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (gnt[1]) begin
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg   <= ST_ARB;
            last_reg    <= PORT_D;
            rd_pend_reg <= 1'b0;
            rd_own_reg  <= PORT_C;
        end else begin
            rd_pend_reg <= m_en & ~m_we;
            if (m_en) begin
                last_reg   <= gnt[1];
                rd_own_reg <= gnt[1];
            end
            case (state_reg)
                ST_ARB:    if (gnt[1] && d_lock) state_reg <= ST_LOCKED;
                ST_LOCKED: if (!d_lock) state_reg <= ST_ARB;
                default:   state_reg <= ST_ARB;
            endcase
        end
    end

    // Read return path; masking with reset drops a read that is in flight when reset hits.
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_ret
        assign rvalid[gi] = reset & rd_pend_reg & (rd_own_reg == 1'(gi));
        assign rdata[gi]  = rvalid[gi] ? m_rdata : '0;
    end

    assign c_rvalid = rvalid[0];
    assign d_rvalid = rvalid[1];
    assign c_rdata  = rdata[0];
    assign d_rdata  = rdata[1];

endmodule
